// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable
//   Run-time loadable, synchronous-read instruction memory for the
//   single-cycle CPU family. A program is streamed in through the load port
//   (EMPTY -> LOAD -> RUN). Fetches are accepted only in RUN and return one
//   cycle later, split into an opcode field (CuOut) and a datapath field.
//   Reads at or above the committed word count return zero, so contents
//   left over from an earlier program are never visible.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   load_start      begin or restart a load at address 0 (from any state)
//   load_valid      load_data holds a word to write this cycle
//   load_data       instruction word to write
//   load_done       end of load; commit the word count and enter RUN
//   load_ready      LOAD state and memory not yet full
//   load_ovf        sticky: a word was dropped because memory was full
//   mem_ready       RUN state
//   loaded_count    number of committed words (ADDR_W+1 bits, holds DEPTH)
//   fetch_req, PC   fetch request and address
//   ins_valid       one-cycle pulse: output fields hold a new fetch
//   CuOut           opcode field, bits [INS_W-1 : INS_W-OPC_W]
//   dataPathOut     remaining low bits of the fetched word
//   halt            fetched word is all zero
//   addr_err        fetched PC >= DEPTH
module instr_mem_loadable #(
    parameter int ADDR_W = 12,
    parameter int INS_W  = 19,
    parameter int OPC_W  = 5,
    parameter int DEPTH  = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [INS_W-1:0]       load_data,
    input  logic                   load_done,
    output logic                   load_ready,
    output logic                   load_ovf,
    output logic                   mem_ready,
    output logic [ADDR_W:0]        loaded_count,
    input  logic                   fetch_req,
    input  logic [ADDR_W-1:0]      PC,
    output logic                   ins_valid,
    output logic [OPC_W-1:0]       CuOut,
    output logic [INS_W-OPC_W-1:0] dataPathOut,
    output logic                   halt,
    output logic                   addr_err
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [1:0]       state;
    logic [ADDR_W:0]  wptr;
    logic [ADDR_W:0]  loadedCount;
    logic             loadOvf;

    logic [INS_W-1:0] mem [DEPTH];
    logic [INS_W-1:0] rdRaw;
    logic             zeroMask;
    logic             insValid;
    logic             addrErr;
    logic [INS_W-1:0] word;

    logic             notFull;
    logic             wrBeat;
    logic             wrEn;
    logic             fetchEn;
    logic [ADDR_W:0]  pcExt;
    logic             pcOutOfRange;
    logic             pcUnloaded;

    assign notFull      = (wptr < DEPTH_C);
    assign wrBeat       = load_valid && notFull;
    // load_start wins over a same-cycle beat: the load restarts empty.
    assign wrEn         = !rst && (state == LOAD) && !load_start && wrBeat;
    // A fetch coinciding with load_start is dropped.
    assign fetchEn      = (state == RUN) && fetch_req && !load_start;
    assign pcExt        = {1'b0, PC};
    assign pcOutOfRange = (pcExt >= DEPTH_C);
    assign pcUnloaded   = (pcExt >= loadedCount);

    // Storage has no reset; stale words are hidden by the loadedCount mask.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wptr[IDX_W-1:0]] <= load_data;
        end
    end

    // Raw read register only; out-of-range/unloaded addresses are forced to
    // zero through zeroMask, which keeps the array a plain synchronous RAM.
    always_ff @(posedge clk) begin
        if (fetchEn) begin
            rdRaw <= mem[PC[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            wptr        <= '0;
            loadedCount <= '0;
            loadOvf     <= 1'b0;
            insValid    <= 1'b0;
            zeroMask    <= 1'b1;
            addrErr     <= 1'b0;
        end else begin
            insValid <= fetchEn;
            if (fetchEn) begin
                zeroMask <= pcOutOfRange || pcUnloaded;
                addrErr  <= pcOutOfRange;
            end

            if (load_start) begin
                state       <= LOAD;
                wptr        <= '0;
                loadedCount <= '0;
                loadOvf     <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (load_valid) begin
                            if (notFull) begin
                                wptr <= wptr + 1'b1;
                            end else begin
                                loadOvf <= 1'b1;
                            end
                        end
                        // A beat in the same cycle as load_done is counted.
                        if (load_done) begin
                            state       <= RUN;
                            loadedCount <= wptr + (ADDR_W + 1)'(wrBeat);
                        end
                    end
                    RUN:     state <= RUN;
                    EMPTY:   state <= EMPTY;
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign word         = zeroMask ? '0 : rdRaw;
    assign CuOut        = word[INS_W-1 -: OPC_W];
    assign dataPathOut  = word[INS_W-OPC_W-1:0];
    assign halt         = (word == '0);
    assign ins_valid    = insValid;
    assign addr_err     = addrErr;
    assign load_ready   = (state == LOAD) && notFull;
    assign load_ovf     = loadOvf;
    assign mem_ready    = (state == RUN);
    assign loaded_count = loadedCount;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

    localparam int AW = 4;
    localparam int IW = 19;
    localparam int OW = 5;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [IW-1:0] load_data = '0;
    logic          load_done = 1'b0;
    logic          load_ready;
    logic          load_ovf;
    logic          mem_ready;
    logic [AW:0]   loaded_count;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] PC = '0;
    logic          ins_valid;
    logic [OW-1:0] CuOut;
    logic [IW-OW-1:0] dataPathOut;
    logic          halt;
    logic          addr_err;

    instr_mem_loadable #(
        .ADDR_W(AW),
        .INS_W (IW),
        .OPC_W (OW),
        .DEPTH (DP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_done   (load_done),
        .load_ready  (load_ready),
        .load_ovf    (load_ovf),
        .mem_ready   (mem_ready),
        .loaded_count(loaded_count),
        .fetch_req   (fetch_req),
        .PC          (PC),
        .ins_valid   (ins_valid),
        .CuOut       (CuOut),
        .dataPathOut (dataPathOut),
        .halt        (halt),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] word;
        logic          err;
    } expT;

    expT           sb [$];
    expT           popped;
    int            checks = 0;
    int            errors = 0;

    // Reference model of the memory contents and load bookkeeping
    logic [IW-1:0] mMem [DP];
    int            mW = 0;
    int            mCount = 0;
    bit            mRun = 0;
    bit            mOvf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic loadStart();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        mW = 0; mCount = 0; mRun = 0; mOvf = 0;
    endtask

    task automatic loadBeat(input logic [IW-1:0] data, input bit done);
        load_valid = 1'b1;
        load_data  = data;
        load_done  = done;
        cyc();
        load_valid = 1'b0;
        load_done  = 1'b0;
        if (mW < DP) begin
            mMem[mW] = data;
            mW++;
        end else begin
            mOvf = 1;
        end
        if (done) begin
            mCount = mW;
            mRun = 1;
        end
    endtask

    task automatic loadDone();
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        mCount = mW;
        mRun = 1;
    endtask

    task automatic fetch(input int pc);
        expT e;
        fetch_req = 1'b1;
        PC = AW'(pc);
        if (mRun) begin
            if (pc >= DP) begin
                e.word = '0; e.err = 1'b1;
            end else if (pc >= mCount) begin
                e.word = '0; e.err = 1'b0;
            end else begin
                e.word = mMem[pc]; e.err = 1'b0;
            end
            sb.push_back(e);
        end
        cyc();
        fetch_req = 1'b0;
    endtask

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (!rst && ins_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_ins_valid", 32'(ins_valid), 32'd0);
            end else begin
                popped = sb.pop_front();
                check("sb_CuOut", 32'(CuOut), 32'(popped.word[IW-1 -: OW]));
                check("sb_dataPathOut", 32'(dataPathOut), 32'(popped.word[IW-OW-1:0]));
                check("sb_halt", 32'(halt), 32'(popped.word == '0));
                check("sb_addr_err", 32'(addr_err), 32'(popped.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) cyc();
        rst = 1'b0;

        // Reset values
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_CuOut", 32'(CuOut), 32'd0);
        check("rst_dataPathOut", 32'(dataPathOut), 32'd0);
        check("rst_halt", 32'(halt), 32'd1);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_load_ovf", 32'(load_ovf), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_loaded_count", 32'(loaded_count), 32'd0);

        // Fetch ignored in EMPTY
        fetch(0);
        check("empty_fetch_valid", 32'(ins_valid), 32'd0);
        check("empty_fetch_halt", 32'(halt), 32'd1);

        // Basic 3-word program
        loadStart();
        check("load_ready_entry", 32'(load_ready), 32'd1);
        check("mem_ready_in_load", 32'(mem_ready), 32'd0);
        loadBeat(19'h1C000, 0);
        loadBeat(19'h5320A, 0);
        loadBeat(19'h00001, 0);
        fetch(0);
        check("load_fetch_valid", 32'(ins_valid), 32'd0);
        check("load_fetch_halt", 32'(halt), 32'd1);
        check("load_fetch_CuOut", 32'(CuOut), 32'd0);
        loadDone();
        check("mem_ready_run", 32'(mem_ready), 32'd1);
        check("count_3", 32'(loaded_count), 32'd3);
        fetch(0);
        check("pc0_CuOut", 32'(CuOut), 32'h07);
        check("pc0_dataPathOut", 32'(dataPathOut), 32'h0000);
        fetch(1);
        cyc();
        check("pulse_low", 32'(ins_valid), 32'd0);
        check("hold_CuOut", 32'(CuOut), 32'h14);
        check("hold_dataPathOut", 32'(dataPathOut), 32'h320A);
        fetch(2);
        check("pc2_dataPathOut", 32'(dataPathOut), 32'd1);
        check("pc2_halt", 32'(halt), 32'd0);
        fetch(3);
        check("pc3_halt", 32'(halt), 32'd1);
        check("pc3_addr_err", 32'(addr_err), 32'd0);
        fetch(9);
        check("pc9_valid", 32'(ins_valid), 32'd1);
        check("pc9_addr_err", 32'(addr_err), 32'd1);

        // Overflow: 10 beats into an 8-word memory
        loadStart();
        for (int i = 0; i < 10; i++) begin
            loadBeat(19'(32'h100 + 32'(i * 3)), 0);
            check("ovf_load_ready", 32'(load_ready), 32'(mW < DP));
            check("ovf_load_ovf", 32'(load_ovf), 32'(mOvf));
        end
        check("ovf_sticky_set", 32'(load_ovf), 32'd1);
        loadDone();
        check("count_full", 32'(loaded_count), 32'd8);
        check("ovf_sticky_run", 32'(load_ovf), 32'd1);
        for (int p = 0; p < DP; p++) fetch(p);
        fetch(9);
        fetch(15);

        // load_start and fetch_req in the same RUN cycle
        load_start = 1'b1;
        fetch_req  = 1'b1;
        PC         = '0;
        cyc();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        mW = 0; mCount = 0; mRun = 0; mOvf = 0;
        check("restart_no_valid", 32'(ins_valid), 32'd0);
        check("restart_mem_ready", 32'(mem_ready), 32'd0);
        check("restart_count", 32'(loaded_count), 32'd0);
        check("restart_ovf_clear", 32'(load_ovf), 32'd0);
        fetch(0);
        check("restart_fetch_ignored", 32'(ins_valid), 32'd0);

        // Reset mid-load, then 1-word reload with load_valid+load_done together
        loadBeat(19'h2AAAA, 0);
        loadBeat(19'h15555, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mW = 0; mCount = 0; mRun = 0; mOvf = 0;
        check("midrst_count", 32'(loaded_count), 32'd0);
        check("midrst_load_ready", 32'(load_ready), 32'd0);
        check("midrst_mem_ready", 32'(mem_ready), 32'd0);
        check("midrst_halt", 32'(halt), 32'd1);
        loadStart();
        loadBeat(19'h0ABCD, 1);
        check("reload_count", 32'(loaded_count), 32'd1);
        check("reload_mem_ready", 32'(mem_ready), 32'd1);
        fetch(0);
        fetch(1);
        check("stale_halt", 32'(halt), 32'd1);
        check("stale_dataPathOut", 32'(dataPathOut), 32'd0);

        // Drain scoreboard with a bounded wait
        cyc();
        for (int k = 0; k < 5 && sb.size() != 0; k++) cyc();
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
